// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predictor and the CPU top level.
//   bp_mode_e  : prediction mode codes (same encoding the CPU drives on 'mode')
//   BP_CTR_RST : value each 2-bit table counter takes on reset / on a not-taken allocate
package branch_predict_unit_pkg;

  typedef enum logic [1:0] {
    BP_NOT_TAKEN = 2'b00,
    BP_TAKEN     = 2'b01,
    BP_DELAY     = 2'b10,
    BP_DYNAMIC   = 2'b11
  } bp_mode_e;

  localparam logic [1:0] BP_CTR_RST   = 2'b01;  // weakly not-taken
  localparam logic [1:0] BP_CTR_ALLOC = 2'b10;  // weakly taken

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up/down counter.
//   clk, rst   : clock, async active-low reset (to RST_VAL)
//   clr        : sync clear to 0 (highest priority)
//   ld, ld_val : sync load
//   inc, dec   : step up / down, holding at all-ones / zero; both set = hold
//   q          : current count
module bp_sat_counter #(
  parameter int             W       = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                                 cnt_d = '0;
    else if (ld)                             cnt_d = ld_val;
    else if (inc && !dec && (cnt_q != '1))   cnt_d = cnt_q + W'(1);
    else if (dec && !inc && (cnt_q != '0))   cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= RST_VAL;
    else      cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor: direct-mapped BHT/BTB held in flops, four prediction modes.
//   IF side : if_pc -> pred_taken / pred_target (combinational)
//   EX side : ex_* resolve a branch, update the table, raise mispredict/redirect_pc
//   keep_slot : delay-slot mode, instruction after the branch survives
//   stats   : saturating resolved-branch / mispredict counts with sync clear
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int ENTRIES    = 16,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic [PC_WIDTH-1:0]   if_pc,
  output logic                  pred_taken,
  output logic [PC_WIDTH-1:0]   pred_target,
  input  logic                  ex_br_valid,
  input  logic [PC_WIDTH-1:0]   ex_pc,
  input  logic                  ex_taken,
  input  logic [PC_WIDTH-1:0]   ex_target,
  input  logic                  ex_pred_taken,
  input  logic [PC_WIDTH-1:0]   ex_pred_target,
  output logic                  mispredict,
  output logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  keep_slot,
  input  logic                  stat_clear,
  output logic [STAT_WIDTH-1:0] stat_branches,
  output logic [STAT_WIDTH-1:0] stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_WIDTH - IDX_W - 2;

  logic [ENTRIES-1:0]               valid_q, valid_d;
  logic [ENTRIES-1:0][TAG_W-1:0]    tag_q, tag_d;
  logic [ENTRIES-1:0][PC_WIDTH-1:0] tgt_q, tgt_d;
  logic [ENTRIES-1:0][1:0]          ctr;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic [1:0]       if_ctr;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[PC_WIDTH-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[PC_WIDTH-1:IDX_W+2];

  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign if_ctr = ctr[if_idx];

  // Lookup reads the registered table, so a same-cycle update is not seen yet.
  always_comb begin
    pred_taken = 1'b0;
    case (mode)
      BP_TAKEN:   pred_taken = if_hit;
      BP_DYNAMIC: pred_taken = if_hit && if_ctr[1];
      default:    pred_taken = 1'b0;
    endcase
  end

  assign pred_target = pred_taken ? tgt_q[if_idx] : if_pc + PC_WIDTH'(4);

  // Table trains in every mode so a later switch to dynamic starts warm.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (ex_br_valid) begin
      if (!ex_hit) begin
        valid_d[ex_idx] = 1'b1;
        tag_d[ex_idx]   = ex_tag;
        tgt_d[ex_idx]   = ex_target;
      end else if (ex_taken) begin
        tgt_d[ex_idx]   = ex_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      tag_q   <= '0;
      tgt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    logic sel;
    assign sel = ex_br_valid && (ex_idx == IDX_W'(i));
    bp_sat_counter #(.W(2), .RST_VAL(BP_CTR_RST)) u_ctr (
      .clk    (clk),
      .rst    (rst),
      .clr    (1'b0),
      .ld     (sel && !ex_hit),
      .ld_val (ex_taken ? BP_CTR_ALLOC : BP_CTR_RST),
      .inc    (sel && ex_hit && ex_taken),
      .dec    (sel && ex_hit && !ex_taken),
      .q      (ctr[i])
    );
  end

  assign mispredict  = ex_br_valid &&
                       ((ex_pred_taken != ex_taken) ||
                        (ex_taken && (ex_pred_target != ex_target)));
  // Delay-slot mode: fall-through skips the slot instruction already executed.
  assign redirect_pc = ex_taken ? ex_target
                                : ex_pc + ((mode == BP_DELAY) ? PC_WIDTH'(8) : PC_WIDTH'(4));
  assign keep_slot   = (mode == BP_DELAY);

  bp_sat_counter #(.W(STAT_WIDTH)) u_stat_br (
    .clk    (clk),
    .rst    (rst),
    .clr    (stat_clear),
    .ld     (1'b0),
    .ld_val ('0),
    .inc    (ex_br_valid),
    .dec    (1'b0),
    .q      (stat_branches)
  );

  bp_sat_counter #(.W(STAT_WIDTH)) u_stat_mp (
    .clk    (clk),
    .rst    (rst),
    .clr    (stat_clear),
    .ld     (1'b0),
    .ld_val ('0),
    .inc    (mispredict),
    .dec    (1'b0),
    .q      (stat_mispred)
  );

  // Byte-offset bits and the counter LSB are architecturally unused here.
  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], ex_pc[1:0], if_ctr[0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_br_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        keep_slot;
  logic        stat_clear;
  logic [3:0]  stat_branches;
  logic [3:0]  stat_mispred;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(.PC_WIDTH(32), .ENTRIES(16), .STAT_WIDTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .mode           (mode),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_br_valid    (ex_br_valid),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .keep_slot      (keep_slot),
    .stat_clear     (stat_clear),
    .stat_branches  (stat_branches),
    .stat_mispred   (stat_mispred)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                    input logic pt, input logic [31:0] ptgt);
    ex_br_valid    = 1'b1;
    ex_pc          = pc;
    ex_taken       = t;
    ex_target      = tgt;
    ex_pred_taken  = pt;
    ex_pred_target = ptgt;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic exp_t, input logic [31:0] exp_tgt);
    if_pc = pc;
    #1;
    chk({tag, "_taken"},  {31'b0, pred_taken}, {31'b0, exp_t});
    chk({tag, "_target"}, pred_target, exp_tgt);
  endtask

  initial begin
    rst = 1'b1; mode = 2'b11; if_pc = 32'h18; stat_clear = 1'b0;
    ex_br_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_target = '0;
    ex_pred_taken = 1'b0; ex_pred_target = '0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;

    // 1: cold table
    look("t1", 32'h18, 1'b0, 32'h1C);
    chk("t1_stat_br", {28'b0, stat_branches}, 32'd0);
    chk("t1_stat_mp", {28'b0, stat_mispred},  32'd0);

    // 2: train 0x10 taken to 0x44 three times
    br(32'h10, 1'b1, 32'h44, 1'b0, 32'h14); #1;
    chk("t2_mp_a", {31'b0, mispredict}, 32'd1);
    chk("t2_redir_a", redirect_pc, 32'h44);
    tick; ex_br_valid = 1'b0;
    look("t2_after1", 32'h10, 1'b1, 32'h44);
    br(32'h10, 1'b1, 32'h44, 1'b1, 32'h44); #1;
    chk("t2_mp_b", {31'b0, mispredict}, 32'd0);
    tick;
    br(32'h10, 1'b1, 32'h44, 1'b1, 32'h44);
    tick; ex_br_valid = 1'b0;
    look("t2_after3", 32'h10, 1'b1, 32'h44);

    // 3: two not-taken -> 11 -> 10 -> 01
    br(32'h10, 1'b0, 32'h44, 1'b1, 32'h44); #1;
    chk("t3_mp", {31'b0, mispredict}, 32'd1);
    chk("t3_redir", redirect_pc, 32'h14);
    tick; ex_br_valid = 1'b0;
    look("t3_ctr10", 32'h10, 1'b1, 32'h44);
    br(32'h10, 1'b0, 32'h44, 1'b1, 32'h44);
    tick; ex_br_valid = 1'b0;
    look("t3_ctr01", 32'h10, 1'b0, 32'h14);
    chk("t3_stat_br", {28'b0, stat_branches}, 32'd5);
    chk("t3_stat_mp", {28'b0, stat_mispred},  32'd3);
    mode = 2'b01;
    look("t3_static_taken", 32'h10, 1'b1, 32'h44);
    mode = 2'b00;
    look("t3_static_nt", 32'h10, 1'b0, 32'h14);

    // 4: delay-slot mode
    mode = 2'b10;
    look("t4_delay", 32'h10, 1'b0, 32'h14);
    chk("t4_keep", {31'b0, keep_slot}, 32'd1);
    br(32'h10, 1'b1, 32'h0C, 1'b0, 32'h18); #1;
    chk("t4_mp_t", {31'b0, mispredict}, 32'd1);
    chk("t4_redir_t", redirect_pc, 32'h0C);
    tick;
    br(32'h10, 1'b0, 32'h0C, 1'b0, 32'h18); #1;
    chk("t4_mp_nt", {31'b0, mispredict}, 32'd0);
    chk("t4_redir_nt", redirect_pc, 32'h18);
    tick; ex_br_valid = 1'b0;
    mode = 2'b11; #1;
    chk("t4_keep_dyn", {31'b0, keep_slot}, 32'd0);

    // 5: 0x50 aliases index 4 with a different tag
    br(32'h50, 1'b1, 32'h80, 1'b0, 32'h54);
    tick; ex_br_valid = 1'b0;
    mode = 2'b01;
    look("t5_alias_old", 32'h10, 1'b0, 32'h14);
    look("t5_alias_new", 32'h50, 1'b1, 32'h80);
    mode = 2'b11;
    br(32'h50, 1'b1, 32'h90, 1'b1, 32'h80);
    look("t5_rbw", 32'h50, 1'b1, 32'h80);
    chk("t5_mp_tgt", {31'b0, mispredict}, 32'd1);
    chk("t5_redir", redirect_pc, 32'h90);
    tick; ex_br_valid = 1'b0;
    look("t5_post", 32'h50, 1'b1, 32'h90);
    chk("t5_stat_br", {28'b0, stat_branches}, 32'd9);
    chk("t5_stat_mp", {28'b0, stat_mispred},  32'd6);

    // 6: stats saturation and clear
    stat_clear = 1'b1;
    tick; stat_clear = 1'b0;
    chk("t6_clr_br", {28'b0, stat_branches}, 32'd0);
    chk("t6_clr_mp", {28'b0, stat_mispred},  32'd0);
    for (int i = 0; i < 20; i++) begin
      br(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
      tick;
    end
    ex_br_valid = 1'b0; #1;
    chk("t6_sat_br", {28'b0, stat_branches}, 32'hF);
    chk("t6_sat_mp", {28'b0, stat_mispred},  32'hF);
    br(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    stat_clear = 1'b1;
    tick; ex_br_valid = 1'b0; stat_clear = 1'b0;
    chk("t6_clrwin_br", {28'b0, stat_branches}, 32'd0);
    chk("t6_clrwin_mp", {28'b0, stat_mispred},  32'd0);
    br(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    tick; tick; ex_br_valid = 1'b0;
    look("t6_pre_rst", 32'h50, 1'b1, 32'h90);
    chk("t6_pre_rst_br", {28'b0, stat_branches}, 32'd2);

    // async reset, checked before any clock edge
    rst = 1'b0;
    #1;
    chk("t6_rst_taken",  {31'b0, pred_taken}, 32'd0);
    chk("t6_rst_target", pred_target, 32'h54);
    chk("t6_rst_br", {28'b0, stat_branches}, 32'd0);
    chk("t6_rst_mp", {28'b0, stat_mispred},  32'd0);
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
